// File: rtl/cpu_decode_queue_if.sv
// Fetch-side and issue-side handshake bundle for the decoded-instruction queue.
// Latency: none (wires only).
// Backpressure: in_ready throttles fetch, out_ready throttles the queue head.
interface cpu_decode_queue_if #(
  parameter int PC_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic [4:0]          out_reg_read_1;
  logic [4:0]          out_reg_read_2;
  logic [4:0]          out_reg_write;
  logic [7:0]          out_class;
  logic                out_could_branch;
  logic                out_is_nop;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_reg_read_1, out_reg_read_2,
           out_reg_write, out_class, out_could_branch, out_is_nop
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_reg_read_1, out_reg_read_2,
           out_reg_write, out_class, out_could_branch, out_is_nop
  );
endinterface

// File: rtl/cpu_decode_queue.sv
// Decoded-instruction ring buffer between fetch and issue; decodes MIPS words at enqueue.
// Latency: entry pushed at edge N is visible at the head after edge N (no empty bypass).
// Backpressure: in_ready low when full (no full bypass); head held until out_ready.
// Optional: CPU_DECODE_QUEUE_DROP_NOP_EN drops architectural NOPs instead of storing them.
module cpu_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  cpu_decode_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rd1;
    logic [4:0]          rd2;
    logic [4:0]          wr;
    logic [7:0]          cls;
    logic                cb;
    logic                nop;
  } entry_t;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic sp, ld, st, alu_r, alu_i, sh, ml, br, c0, ex, imm, jmp;
  entry_t d;

  assign op    = bus.in_inst[31:26];
  assign rs    = bus.in_inst[25:21];
  assign rt    = bus.in_inst[20:16];
  assign rd    = bus.in_inst[15:11];
  assign funct = bus.in_inst[5:0];

  assign sp    = (op == 6'd0);
  assign ld    = (op[5:3] == 3'b100);
  assign st    = (op[5:3] == 3'b101);
  assign alu_r = sp && (funct[5:4] == 2'b10);
  assign alu_i = (op[5:3] == 3'b001);
  assign sh    = sp && (funct[5:3] == 3'b000);
  assign ml    = sp && ((funct[5:3] == 3'b010) || (funct[5:3] == 3'b011));
  assign br    = (sp && (funct[5:1] == 5'b00100)) || (op[5:1] == 5'b00001) ||
                 (op == 6'b000001) || (op[5:2] == 4'b0001);
  assign c0    = (op == 6'b010000);
  assign ex    = sp && (funct[5:1] == 5'b00110);
  assign imm   = ld || st || alu_i || (op == 6'b000001) || (op[5:2] == 4'b0001);
  assign jmp   = (op[5:1] == 5'b00001);

  // Build the decoded entry for the incoming instruction.
  always_comb begin
    d      = '0;
    d.inst = bus.in_inst;
    d.pc   = bus.in_pc;
    d.cls  = {ex, c0, br, ml, sh, alu_r | alu_i, st, ld};
    d.rd1  = (jmp || ex) ? 5'd0 : rs;
    d.rd2  = (imm || jmp) ? 5'd0 : rt;
    if ((op == 6'b000010) || st)
      d.wr = 5'd0;
    else if ((op == 6'b000011) || ((op == 6'b000001) && (rt[4:1] == 4'b1000)))
      d.wr = 5'd31;
    else if (br)
      d.wr = 5'd0;
    else if (ld || alu_i)
      d.wr = rt;
    else
      d.wr = rd;
    d.cb  = ld || st || br || ex || c0 || (sp && (funct == 6'b100000)) ||
            (sp && (funct == 6'b100010)) || (op == 6'b001000);
    d.nop = !d.cb && ((alu_r && (rd == 5'd0)) || (alu_i && (rt == 5'd0)) ||
                      (sh && (rd == 5'd0)));
  end

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            push, pop, wr_en;
  entry_t          head_e;

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
`ifdef CPU_DECODE_QUEUE_DROP_NOP_EN
  assign wr_en         = push && !d.nop;
`else
  assign wr_en         = push;
`endif
  assign head_e        = mem[head];

  // Storage array: written at tail, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !flush)
      mem[tail] <= d;
  end

  // Pointer and occupancy update; flush beats push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + PW'(1);
      if (pop)   head <= head + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.out_inst         = bus.out_valid ? head_e.inst : '0;
  assign bus.out_pc           = bus.out_valid ? head_e.pc   : '0;
  assign bus.out_reg_read_1   = bus.out_valid ? head_e.rd1  : '0;
  assign bus.out_reg_read_2   = bus.out_valid ? head_e.rd2  : '0;
  assign bus.out_reg_write    = bus.out_valid ? head_e.wr   : '0;
  assign bus.out_class        = bus.out_valid ? head_e.cls  : '0;
  assign bus.out_could_branch = bus.out_valid && head_e.cb;
`ifdef CPU_DECODE_QUEUE_DROP_NOP_EN
  assign bus.out_is_nop       = 1'b0;
`else
  assign bus.out_is_nop       = bus.out_valid && head_e.nop;
`endif
endmodule

// File: tb/tb_cpu_decode_queue.sv
// Randomized bench for cpu_decode_queue against a queue-based reference model.
module tb_cpu_decode_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;

  cpu_decode_queue_if #(.PC_WIDTH(32)) bus();

  cpu_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t q[$];

  typedef struct packed {
    logic [4:0] r1, r2, wr;
    logic [7:0] cls;
    logic       cb, nop;
  } dec_t;

  // Reference decode written from the classification rules with integer ranges.
  function automatic dec_t ref_dec(input logic [31:0] inst);
    int op, f, rs, rt, rd;
    bit sp, ld, st, alr, ali, sh, ml, br, c0, ex, imm, jj;
    dec_t d;
    op = int'(inst[31:26]); rs = int'(inst[25:21]); rt = int'(inst[20:16]);
    rd = int'(inst[15:11]); f = int'(inst[5:0]);
    sp  = (op == 0);
    ld  = (op >= 32 && op < 40);
    st  = (op >= 40 && op < 48);
    alr = sp && f >= 32 && f < 48;
    ali = (op >= 8 && op < 16);
    sh  = sp && f < 8;
    ml  = sp && f >= 16 && f < 32;
    br  = (sp && (f == 8 || f == 9)) || op == 2 || op == 3 || op == 1 || (op >= 4 && op < 8);
    c0  = (op == 16);
    ex  = sp && (f == 12 || f == 13);
    imm = ld || st || ali || op == 1 || (op >= 4 && op < 8);
    jj  = (op == 2 || op == 3);
    d.cls = {ex, c0, br, ml, sh, alr | ali, st, ld};
    d.r1  = (jj || ex) ? 5'd0 : 5'(rs);
    d.r2  = (imm || jj) ? 5'd0 : 5'(rt);
    if (op == 2 || st) d.wr = 5'd0;
    else if (op == 3 || (op == 1 && (rt == 16 || rt == 17))) d.wr = 5'd31;
    else if (br) d.wr = 5'd0;
    else if (ld || ali) d.wr = 5'(rt);
    else d.wr = 5'(rd);
    d.cb  = ld || st || br || ex || c0 || (sp && f == 32) || (sp && f == 34) || op == 8;
    d.nop = !d.cb && ((alr && rd == 0) || (ali && rt == 0) || (sh && rd == 0));
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int ops [18] = '{0, 0, 0, 1, 2, 3, 4, 5, 8, 9, 12, 15, 16, 35, 43, 32, 40, 17};
    int fns [15] = '{0, 2, 8, 9, 12, 13, 16, 24, 25, 32, 33, 34, 37, 42, 26};
    w = $urandom;
    w[31:26] = 6'(ops[$urandom_range(0, 17)]);
    if (w[31:26] == 6'd0) w[5:0] = 6'(fns[$urandom_range(0, 14)]);
    if ($urandom_range(0, 3) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[20:16] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[20:16] = 5'(16 + $urandom_range(0, 1));
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: update occupancy/order on each active edge.
  always @(posedge clk or posedge rst) begin
    bit   do_pop, do_push;
    dec_t dn;
    if (rst) q.delete();
    else if (flush) q.delete();
    else begin
      do_pop  = (q.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && (q.size() != DEPTH);
      dn      = ref_dec(bus.in_inst);
`ifdef CPU_DECODE_QUEUE_DROP_NOP_EN
      if (dn.nop) do_push = 1'b0;
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{bus.in_inst, bus.in_pc});
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    dec_t        e;
    logic [31:0] ei, ep;
    bit          nonempty;
    nonempty = (q.size() != 0);
    chk("in_ready", bus.in_ready, q.size() != DEPTH);
    chk("count", count, q.size());
    chk("out_valid", bus.out_valid, nonempty);
    if (nonempty) begin
      e = ref_dec(q[0].inst); ei = q[0].inst; ep = q[0].pc;
    end else begin
      e = '0; ei = '0; ep = '0;
    end
`ifdef CPU_DECODE_QUEUE_DROP_NOP_EN
    e.nop = 1'b0;
`endif
    chk("out_inst", bus.out_inst, ei);
    chk("out_pc", bus.out_pc, ep);
    chk("out_reg_read_1", bus.out_reg_read_1, e.r1);
    chk("out_reg_read_2", bus.out_reg_read_2, e.r2);
    chk("out_reg_write", bus.out_reg_write, e.wr);
    chk("out_class", bus.out_class, e.cls);
    chk("out_could_branch", bus.out_could_branch, e.cb);
    chk("out_is_nop", bus.out_is_nop, e.nop);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    step();

    send(32'h8C880004, 32'h100);
    chk("lw_valid", bus.out_valid, 1);
    chk("lw_pc", bus.out_pc, 32'h100);
    chk("lw_class", bus.out_class, 8'h01);
    chk("lw_r1", bus.out_reg_read_1, 4);
    chk("lw_r2", bus.out_reg_read_2, 0);
    chk("lw_wr", bus.out_reg_write, 8);
    chk("lw_cb", bus.out_could_branch, 1);
    pop1();

    send(32'h0C000010, 32'h104);
    chk("jal_r1", bus.out_reg_read_1, 0);
    chk("jal_r2", bus.out_reg_read_2, 0);
    chk("jal_wr", bus.out_reg_write, 31);
    chk("jal_class", bus.out_class, 8'h20);
    pop1();

    send(32'h04110003, 32'h108);
    chk("bgezal_wr", bus.out_reg_write, 31);
    chk("bgezal_r1", bus.out_reg_read_1, 0);
    pop1();

    send(32'h00000021, 32'h10C);
`ifdef CPU_DECODE_QUEUE_DROP_NOP_EN
    chk("nop_drop_count", count, 0);
    chk("nop_drop_valid", bus.out_valid, 0);
`else
    chk("nop_flag", bus.out_is_nop, 1);
    pop1();
`endif

    // Fill past capacity with the head stalled.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = 32'h00000020 | ((i + 1) << 11);
      bus.in_pc    = 32'h200 + 4 * i;
      step();
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_count", count, 4);
    chk("full_head_pc", bus.out_pc, 32'h200);

    // Simultaneous push/pop across the pointer wrap (no full bypass: first push is refused).
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = 32'h00000020 | ((i + 10) << 11);
      bus.in_pc    = 32'h300 + 4 * i;
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("wrap_count", count, 3);
    chk("wrap_head_pc", bus.out_pc, 32'h314);

    // Flush with a simultaneous push and pop at count 3.
    flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_pc = 32'h777;
    step();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_pc", bus.out_pc, 0);
    chk("flush_inst", bus.out_inst, 0);
    chk("flush_in_ready", bus.in_ready, 1);

    // Asynchronous reset between edges with two entries held.
    send(32'h8C880004, 32'h400);
    send(32'h8C880004, 32'h404);
    chk("prerst_count", count, 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", bus.out_valid, 0);
    #3 rst = 1'b0;
    send(32'h8C880004, 32'h500);
    chk("postrst_pc", bus.out_pc, 32'h500);
    pop1();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.out_ready = ($urandom_range(0, 99) < 50);
      flush         = ($urandom_range(0, 99) < 3);
      bus.in_inst   = rand_inst();
      bus.in_pc     = $urandom;
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
